// File: rtl/pulse_generator_pkg.sv
// Shared constants, state encoding and width helper for the pulse generator.
package pulse_generator_pkg;

    localparam int HIGH_CYCLES_DEF = 4;
    localparam int LOW_CYCLES_DEF  = 2;
    localparam int PENDING_MAX_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        PULSE_HIGH,
        PULSE_LOW
    } pulse_state_t;

    // $clog2 that never returns less than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter that holds at zero; load takes priority over count.
module pulse_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_low,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         count,
    output logic         zero
);

    logic [W-1:0] value_q;

    always_ff @(posedge clk) begin
        if (!reset_low) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= load_value;
        end else if (count && (value_q != '0)) begin
            value_q <= value_q - W'(1);
        end
    end

    assign zero = (value_q == '0);

endmodule

// File: rtl/pulse_generator.sv
// Turns single-cycle triggers into HIGH_CYCLES-wide pulses separated by at
// least LOW_CYCLES low clocks, queueing up to PENDING_MAX extra requests.
module pulse_generator
    import pulse_generator_pkg::*;
#(
    parameter int HIGH_CYCLES = HIGH_CYCLES_DEF,
    parameter int LOW_CYCLES  = LOW_CYCLES_DEF,
    parameter int PENDING_MAX = PENDING_MAX_DEF,
    localparam int PW = clog2_min1(PENDING_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset_low,
    input  logic          trigger,
    output logic          level,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          overflow,
    output pulse_state_t  state
);

    localparam int TW = clog2_min1((HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES);
    localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYCLES - 1);
    localparam logic [TW-1:0] LOW_LOAD  = TW'(LOW_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(PENDING_MAX);

    pulse_state_t  state_q, state_next;
    logic          level_q, overflow_q;
    logic [PW-1:0] pending_q, pending_next;
    logic          timer_load, timer_count, timer_zero;
    logic [TW-1:0] timer_value;
    logic          consume, dequeue, enqueue, drop;

    pulse_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset_low  (reset_low),
        .load       (timer_load),
        .load_value (timer_value),
        .count      (timer_count),
        .zero       (timer_zero)
    );

    always_comb begin
        state_next  = state_q;
        timer_load  = 1'b0;
        timer_value = '0;
        timer_count = 1'b0;
        consume     = 1'b0;
        dequeue     = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_next  = PULSE_HIGH;
                    timer_load  = 1'b1;
                    timer_value = HIGH_LOAD;
                    consume     = 1'b1;
                end
            end
            PULSE_HIGH: begin
                if (timer_zero) begin
                    state_next  = PULSE_LOW;
                    timer_load  = 1'b1;
                    timer_value = LOW_LOAD;
                end else begin
                    timer_count = 1'b1;
                end
            end
            PULSE_LOW: begin
                if (!timer_zero) begin
                    timer_count = 1'b1;
                end else if (pending_q != '0) begin
                    // Queued requests win over a fresh trigger, which then enqueues.
                    state_next  = PULSE_HIGH;
                    timer_load  = 1'b1;
                    timer_value = HIGH_LOAD;
                    dequeue     = 1'b1;
                end else if (trigger) begin
                    state_next  = PULSE_HIGH;
                    timer_load  = 1'b1;
                    timer_value = HIGH_LOAD;
                    consume     = 1'b1;
                end else begin
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        enqueue      = trigger && !consume;
        pending_next = pending_q;
        drop         = 1'b0;
        if (dequeue && !enqueue) begin
            pending_next = pending_q - PW'(1);
        end else if (enqueue && !dequeue) begin
            if (pending_q < PEND_MAX) begin
                pending_next = pending_q + PW'(1);
            end else begin
                drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_low) begin
            state_q    <= IDLE;
            level_q    <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_next;
            level_q    <= (state_next == PULSE_HIGH);
            pending_q  <= pending_next;
            overflow_q <= drop;
        end
    end

    assign level    = level_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) || (pending_q != '0);
    assign state    = state_q;

endmodule

// File: tb/tb_pulse_generator.sv
// Three pulse_generator configurations share one stimulus stream; a time-based
// pulse-schedule model predicts every output each cycle.
module tb_pulse_generator;
  import pulse_generator_pkg::*;

  logic clk = 1'b0;
  logic reset_low = 1'b0;
  logic trigger = 1'b0;

  logic [2:0]   level_w, busy_w, ovf_w;
  logic [1:0]   pend0, pend1;
  logic [0:0]   pend2;
  pulse_state_t st0, st1, st2;

  int n_cmp = 0;
  int n_err = 0;

  // model: parameters and schedule state per instance
  int m_h[3] = '{4, 3, 1};
  int m_l[3] = '{2, 2, 1};
  int m_m[3] = '{2, 2, 0};
  int m_start[3] = '{-1000, -1000, -1000};
  int m_avail[3] = '{0, 0, 0};
  int m_pend[3]  = '{0, 0, 0};
  int m_ovf[3]   = '{0, 0, 0};
  int m_level[3] = '{0, 0, 0};
  int m_busy[3]  = '{0, 0, 0};
  int m_idle[3]  = '{1, 1, 1};
  int t = 0;

  always #5 clk = ~clk;

  pulse_generator #(.HIGH_CYCLES(4), .LOW_CYCLES(2), .PENDING_MAX(2)) u0 (
    .clk(clk), .reset_low(reset_low), .trigger(trigger), .level(level_w[0]),
    .busy(busy_w[0]), .pending(pend0), .overflow(ovf_w[0]), .state(st0));
  pulse_generator #(.HIGH_CYCLES(3), .LOW_CYCLES(2), .PENDING_MAX(2)) u1 (
    .clk(clk), .reset_low(reset_low), .trigger(trigger), .level(level_w[1]),
    .busy(busy_w[1]), .pending(pend1), .overflow(ovf_w[1]), .state(st1));
  pulse_generator #(.HIGH_CYCLES(1), .LOW_CYCLES(1), .PENDING_MAX(0)) u2 (
    .clk(clk), .reset_low(reset_low), .trigger(trigger), .level(level_w[2]),
    .busy(busy_w[2]), .pending(pend2), .overflow(ovf_w[2]), .state(st2));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at t=%0d: got %0d expected %0d", name, t - 1, act, exp);
    end
  endtask

  // A pulse starting at edge s is high s..s+H-1, low until s+H+L-1;
  // the next pulse may start at s+H+L.
  task automatic model_step(input int i, input logic tr, input logic rl);
    if (!rl) begin
      m_pend[i]  = 0;
      m_ovf[i]   = 0;
      m_avail[i] = t;
      m_start[i] = -1000;
    end else begin
      m_ovf[i] = 0;
      if (t >= m_avail[i] && (m_pend[i] > 0 || tr)) begin
        if (m_pend[i] > 0 && !tr) m_pend[i]--;
        m_start[i] = t;
        m_avail[i] = t + m_h[i] + m_l[i];
      end else if (tr) begin
        if (m_pend[i] < m_m[i]) m_pend[i]++;
        else m_ovf[i] = 1;
      end
    end
    m_level[i] = (t >= m_start[i] && t < m_start[i] + m_h[i]) ? 1 : 0;
    m_idle[i]  = (t >= m_avail[i]) ? 1 : 0;
    m_busy[i]  = (!m_idle[i] || m_pend[i] > 0) ? 1 : 0;
  endtask

  function automatic int dut_pend(input int i);
    case (i)
      0: return int'(pend0);
      1: return int'(pend1);
      default: return int'(pend2);
    endcase
  endfunction

  function automatic int dut_idle(input int i);
    case (i)
      0: return int'(st0 == IDLE);
      1: return int'(st1 == IDLE);
      default: return int'(st2 == IDLE);
    endcase
  endfunction

  // compare process: model advances on each edge, DUT checked 1 time unit later
  always begin
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i, trigger, reset_low);
    t++;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_level", i), int'(level_w[i]), m_level[i]);
      chk($sformatf("u%0d_busy", i), int'(busy_w[i]), m_busy[i]);
      chk($sformatf("u%0d_overflow", i), int'(ovf_w[i]), m_ovf[i]);
      chk($sformatf("u%0d_pending", i), dut_pend(i), m_pend[i]);
      chk($sformatf("u%0d_idle", i), dut_idle(i), m_idle[i]);
    end
  end

  task automatic drive_cycle(input logic tr, input logic rl);
    @(negedge clk);
    trigger   = tr;
    reset_low = rl;
    @(posedge clk);
    #2;
  endtask

  function automatic int bit_at(input string s, input int c);
    return (s[c] == "1") ? 1 : 0;
  endfunction

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) drive_cycle(1'b0, 1'b1);
  endtask

  string tp, rp, e0, e1, e2;
  int p;

  initial begin
    // reset
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b0, 1'b0);
      chk("rst_level", int'(level_w[0]), 0);
      chk("rst_busy", int'(busy_w[0]), 0);
      chk("rst_pending", int'(pend0), 0);
      chk("rst_overflow", int'(ovf_w[0]), 0);
    end
    idle_cycles(3);

    // single trigger: u0 (4/2) and u2 (1/1)
    tp = "1000000000";
    e0 = "1111000000"; e1 = "1111110000";
    e2 = "1000000000";
    for (int c = 0; c < 10; c++) begin
      drive_cycle(bit_at(tp, c) == 1, 1'b1);
      chk("single_u0_level", int'(level_w[0]), bit_at(e0, c));
      chk("single_u0_busy", int'(busy_w[0]), bit_at(e1, c));
      chk("single_u0_pending", int'(pend0), 0);
      chk("single_u2_level", int'(level_w[2]), bit_at(e2, c));
      chk("single_u2_busy", int'(busy_w[2]), (c < 2) ? 1 : 0);
    end

    // burst of four triggers into u1 (3/2, queue 2)
    tp = "11110000000000000000";
    e0 = "11100111001110000000";
    e1 = "00010000000000000000";
    for (int c = 0; c < 20; c++) begin
      drive_cycle(bit_at(tp, c) == 1, 1'b1);
      chk("burst_u1_level", int'(level_w[1]), bit_at(e0, c));
      chk("burst_model_level", m_level[1], bit_at(e0, c));
      chk("burst_u1_overflow", int'(ovf_w[1]), bit_at(e1, c));
      chk("burst_u1_busy", int'(busy_w[1]), (c < 15) ? 1 : 0);
      if (c == 2) begin
        chk("burst_u1_pending", int'(pend1), 2);
        chk("burst_model_pending", m_pend[1], 2);
      end
    end

    // trigger held high: u2 (1/1, no queue)
    e0 = "101010101010";
    e1 = "010101010101";
    for (int c = 0; c < 12; c++) begin
      drive_cycle(1'b1, 1'b1);
      chk("held_u2_level", int'(level_w[2]), bit_at(e0, c));
      chk("held_u2_overflow", int'(ovf_w[2]), bit_at(e1, c));
      chk("held_u2_pending", int'(pend2), 0);
    end
    idle_cycles(30);

    // trigger on the final low cycle with a full queue: u0 (4/2, queue 2)
    tp = "111000100000000000000000000000";
    for (int c = 0; c < 30; c++) begin
      drive_cycle(bit_at(tp, c) == 1, 1'b1);
      if (c == 2) chk("full_u0_pending_c2", int'(pend0), 2);
      if (c == 5) chk("full_u0_level_c5", int'(level_w[0]), 0);
      if (c == 6) begin
        chk("full_u0_pending_c6", int'(pend0), 2);
        chk("full_u0_overflow_c6", int'(ovf_w[0]), 0);
        chk("full_u0_level_c6", int'(level_w[0]), 1);
      end
      if (c == 24) chk("full_u0_busy_c24", int'(busy_w[0]), 0);
    end
    idle_cycles(5);

    // reset in the middle of a queued burst
    tp = "1110100000";
    rp = "1101111111";
    for (int c = 0; c < 10; c++) begin
      drive_cycle(bit_at(tp, c) == 1, bit_at(rp, c) == 1);
      if (c == 2) begin
        chk("midrst_u0_level", int'(level_w[0]), 0);
        chk("midrst_u0_pending", int'(pend0), 0);
        chk("midrst_u0_busy", int'(busy_w[0]), 0);
        chk("midrst_u0_overflow", int'(ovf_w[0]), 0);
      end
      if (c == 3) chk("midrst_u0_busy_c3", int'(busy_w[0]), 0);
      if (c == 4) chk("midrst_u0_level_c4", int'(level_w[0]), 1);
    end
    idle_cycles(20);

    // randomized traffic with varying density and occasional resets
    p = 30;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) p = $urandom_range(5, 95);
      drive_cycle($urandom_range(0, 99) < p, $urandom_range(0, 199) != 0);
    end
    idle_cycles(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_generator.md
# pulse_generator

Converts single-cycle trigger requests into clean, timed level pulses on a registered output line. Each pulse has a fixed high time followed by a guaranteed minimum low gap, so downstream logic sampling the line sees exactly one rising and one falling edge per request. Triggers arriving while a pulse is in flight are queued in a saturating pending counter; excess triggers are dropped and flagged. The block sits on the driving side of any single-wire strobe/handshake line that is consumed by edge detection in the same clock domain.

## Interface
- HIGH_CYCLES, 4, length of the high phase in clocks, ≥1
- LOW_CYCLES, 2, minimum low gap after each pulse in clocks, ≥1
- PENDING_MAX, 2, maximum queued triggers, ≥0 (0 = no queue)
- clk  in  1  system clock, all logic on posedge
- reset_low  in  1  synchronous, active-low reset
- trigger  in  1  request one pulse; sampled every clock, one pulse per high cycle
- level  out  1  registered pulse output
- busy  out  1  HIGH while state ≠ IDLE or pending ≠ 0
- pending  out  $clog2(PENDING_MAX+1) (min 1)  queued trigger count
- overflow  out  1  registered one-cycle pulse: a trigger was dropped

## Operation
- Reset (reset_low == LOW at a clock edge): state IDLE, level LOW, pending 0, overflow LOW, timer 0; busy therefore LOW. Applies mid-pulse: level drops LOW on that edge and the queue is discarded.
- States: IDLE, PULSE_HIGH, PULSE_LOW.
- IDLE: if trigger → PULSE_HIGH, level HIGH, timer = HIGH_CYCLES−1; the trigger is consumed directly and is not counted in pending. pending is always 0 in IDLE.
- PULSE_HIGH: while timer ≠ 0, decrement. At timer == 0 → PULSE_LOW, level LOW, timer = LOW_CYCLES−1.
- PULSE_LOW: while timer ≠ 0, decrement. At timer == 0: if pending ≠ 0 → PULSE_HIGH and pending−1; else if trigger → PULSE_HIGH, trigger consumed directly; else → IDLE.
- Trigger while not consumed directly: if pending < PENDING_MAX then pending+1, else drop and assert overflow on the next cycle.
- Simultaneous dequeue and enqueue on the final PULSE_LOW cycle: net pending unchanged, no overflow even when pending == PENDING_MAX.
- Timer width: $clog2(max(HIGH_CYCLES, LOW_CYCLES)), minimum 1 bit. pending saturates and never wraps.

## Timing
- Label cycle k as the interval after clock edge k.
- Trigger sampled at edge N from IDLE → level HIGH for cycles N..N+HIGH_CYCLES−1, LOW from cycle N+HIGH_CYCLES, for at least LOW_CYCLES cycles.
- Queued pulse period: exactly HIGH_CYCLES+LOW_CYCLES clocks, with no idle cycle inserted.
- busy goes HIGH in the cycle level first goes HIGH. It falls in the first cycle of IDLE, LOW_CYCLES cycles after the last falling edge.
- overflow is HIGH for exactly the one cycle following the dropped trigger's sampling edge.

## Structure
- Shared package: HIGH/LOW constants (existing) and the state enum typedef pulse_state_t {IDLE, PULSE_HIGH, PULSE_LOW}.
- One sub-module: pulse_timer, a loadable down-counter.
  - Ports: clk, reset_low, load, load_value, count, zero.
  - The FSM, queue counter and output registers stay in pulse_generator.

## Test plan
- HIGH=4, LOW=2, single trigger at edge 0 → level HIGH cycles 0–3, LOW from 4; busy LOW from cycle 6; pending stays 0.
- HIGH=3, LOW=2, PENDING_MAX=2, triggers at edges 0,1,2,3:
  - pending reaches 2 at cycle 2; overflow HIGH in cycle 3 only.
  - level HIGH at 0–2, 5–7, 10–12.
  - busy LOW from cycle 15.
- Trigger held HIGH continuously with PENDING_MAX=0 → pulses HIGH/LOW back-to-back, period HIGH+LOW; overflow HIGH on every cycle except the pulse-start cycles.
- Trigger on the final PULSE_LOW cycle with pending == PENDING_MAX → pending unchanged, overflow stays LOW, next pulse starts immediately.
- reset_low LOW at edge 2 of a queued burst → level, pending, busy and overflow are all 0 in cycle 2; a trigger at edge 4 starts a fresh pulse at cycle 4.
- HIGH=1, LOW=1, single trigger → one-cycle HIGH pulse, then one LOW cycle, then IDLE.
